countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Four-digit BCD countdown timer, the down-counting counterpart to the stopwatch up-counter.
- Loads a preset from switches, decrements once per `tick` while running, stops at 0000 and flags expiry.
- Sits between the 1 Hz/100 Hz tick divider and the seven-segment mux/decoder; the digit outputs drive the same display path as the stopwatch.

Parameters:
- DEFAULT_PRESET, 16'h0100, BCD preset {seg3,seg2,seg1,seg0} loaded when mode = 2'b01. Each nibble must be 0-9.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-clk-wide count-enable pulse from the divider.
- stopStart  input  1  one-clk-wide debounced button pulse; toggles run/pause.
- load  input  1  one-clk-wide pulse; loads the preset.
- mode  input  2  preset select: 00 = switches, 01 = DEFAULT_PRESET, 10/11 = load ignored.
- sw  input  8  switch preset: sw[7:4] -> seg3, sw[3:0] -> seg2.
- seg0  output  4  BCD digit 0 (least significant).
- seg1  output  4  BCD digit 1.
- seg2  output  4  BCD digit 2.
- seg3  output  4  BCD digit 3 (most significant).
- running  output  1  high while in state RUN.
- done  output  1  high while in state DONE.
- expired  output  1  single-clk pulse on the edge the count reaches 0000.

Behaviour:
- All outputs are registered. Reset (synchronous, active-high) sets seg0..seg3 = 0, running = 0, done = 0, expired = 0, state = IDLE.
- States: IDLE (loaded or cleared, not counting), RUN, PAUSE, DONE.
- Per-edge priority: reset > load > stopStart > tick. Only the highest-priority event acts; lower ones in the same cycle are dropped.
- load, accepted in IDLE, PAUSE or DONE:
  - mode 00: seg3 = sw[7:4], seg2 = sw[3:0], seg1 = seg0 = 0. Any switch nibble > 9 is clamped to 9.
  - mode 01: digits = DEFAULT_PRESET.
  - State -> IDLE; done = 0.
  - mode 10/11: no change.
  - load in RUN: ignored.
- stopStart:
  - IDLE with count != 0000 -> RUN.
  - IDLE with count == 0000: ignored.
  - RUN -> PAUSE; PAUSE -> RUN.
  - DONE: ignored (a load is required first).
- tick in RUN: BCD decrement by one with borrow chain.
  - A digit at 0 that borrows becomes 9, and the borrow propagates to the next digit.
  - Update latency: digits change on the same edge that samples tick.
  - If the count is 0001 before the tick, it becomes 0000, state -> DONE, and expired = 1 for that one cycle.
- tick in IDLE, PAUSE or DONE: ignored, digits hold.
- The count never wraps below 0000. The decrement path is never entered at 0000.
- running = (state == RUN) and done = (state == DONE); both are registered and update with the state.
- expired defaults to 0 every cycle unless set by the terminal decrement.
- Reset mid-RUN: takes effect on the next edge, regardless of tick, load or stopStart.
- Digits are always valid BCD (0-9) in every state.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: on the terminal tick, the digits reload the last accepted preset (held in an internal 16-bit register updated on each accepted load), state stays RUN, and expired pulses one cycle. DONE is never entered from RUN and done stays 0.
  - If the last preset is 0000, the timer goes to DONE as in normal mode.
  - Reset clears the preset register to 0000.
- Not defined: no preset register; terminal behaviour is as specified above.

Test Plan:
- reset; mode = 00, sw = 8'h12, load -> digits 1200, IDLE, running = 0; stopStart -> running = 1; 3 ticks -> 1197.
- Borrow chain: preset 1000 via sw = 8'h10, run, 1 tick -> 0999; load sw = 8'hAF -> digits 9900 (clamp).
- Terminal: preset 0100, run 100 ticks -> 0000, expired high exactly 1 clk, done = 1; further ticks and stopStart -> no change.
- Priority: in RUN assert stopStart and tick on the same edge -> PAUSE, count unchanged. Assert load and stopStart together in PAUSE -> preset loaded, IDLE.
- Reset mid-run: at count 0734 assert reset with tick -> 0000, IDLE, all flags 0. Then stopStart -> stays IDLE.
- COUNTDOWN_AUTO_RELOAD_EN: mode = 01 (DEFAULT_PRESET 0100), run 100 ticks -> expired pulse, digits 0100, running = 1, done = 0. The 200th tick pulses expired again.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: four-digit BCD countdown with preset load, run/pause and expiry flag.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN reloads the last accepted preset on expiry.
module countdown_timer #(
  parameter logic [15:0] DEFAULT_PRESET = 16'h0100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       stopStart,
  input  logic       load,
  input  logic [1:0] mode,
  input  logic [7:0] sw,
  output logic [3:0] seg0,
  output logic [3:0] seg1,
  output logic [3:0] seg2,
  output logic [3:0] seg3,
  output logic       running,
  output logic       done,
  output logic       expired
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state;
  logic [15:0] cnt, dec, ld_val;
  logic [4:0] br;
  logic [3:0] hi, lo;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0] preset;
`endif
  assign {seg3, seg2, seg1, seg0} = cnt;
  assign hi = sw[7:4] > 4'd9 ? 4'd9 : sw[7:4];
  assign lo = sw[3:0] > 4'd9 ? 4'd9 : sw[3:0];
  assign ld_val = mode[0] ? DEFAULT_PRESET : {hi, lo, 8'h00};
  assign br[0] = 1'b1;
  // borrow ripples upward through every digit sitting at zero
  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign dec[4*i+:4] = br[i] ? (cnt[4*i+:4] == 4'd0 ? 4'd9 : cnt[4*i+:4] - 4'd1) : cnt[4*i+:4];
    assign br[i+1] = br[i] && cnt[4*i+:4] == 4'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 16'h0000;
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      preset  <= 16'h0000;
`endif
    end else begin
      expired <= 1'b0;
      if (load) begin
        if (state != RUN && !mode[1]) begin
          cnt     <= ld_val;
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          preset  <= ld_val;
`endif
        end
      end else if (stopStart) begin
        if ((state == IDLE && cnt != 16'h0000) || state == PAUSE) begin
          state   <= RUN;
          running <= 1'b1;
        end else if (state == RUN) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else if (tick && state == RUN && cnt != 16'h0000) begin
        if (cnt == 16'h0001) begin
          expired <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (preset != 16'h0000) begin
            cnt <= preset;
          end else begin
            cnt     <= 16'h0000;
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end
`else
          cnt     <= 16'h0000;
          state   <= DONE;
          running <= 1'b0;
          done    <= 1'b1;
`endif
        end else begin
          cnt <= dec;
        end
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven and sequence checks of countdown_timer with a scoreboard queue.
module tb_countdown_timer;
  typedef struct {
    logic        rst, tk, ss, ld;
    logic [1:0]  md;
    logic [7:0]  sw;
    logic [15:0] cnt;
    logic        run, dn, ex;
    string       name;
  } vec_t;

  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, stopStart = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] sw = 8'h00;
  logic [3:0] seg0, seg1, seg2, seg3;
  logic running, done, expired;
  int checks = 0, errors = 0;
  vec_t sb[$];
  vec_t tbl[16];

  countdown_timer dut (
    .clk(clk), .reset(reset), .tick(tick), .stopStart(stopStart), .load(load),
    .mode(mode), .sw(sw), .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .running(running), .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic tk, logic ss, logic ld, logic [1:0] md,
                              logic [7:0] s, logic [15:0] c, logic r, logic d, logic e, string n);
    vec_t v;
    v.rst = rst; v.tk = tk; v.ss = ss; v.ld = ld; v.md = md; v.sw = s;
    v.cnt = c; v.run = r; v.dn = d; v.ex = e; v.name = n;
    return v;
  endfunction

  function automatic logic [15:0] bcd(int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    reset = v.rst; tick = v.tk; stopStart = v.ss; load = v.ld; mode = v.md; sw = v.sw;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if ({seg3, seg2, seg1, seg0, running, done, expired} !== {e.cnt, e.run, e.dn, e.ex}) begin
      errors++;
      $display("FAIL %s: got digits=%h run=%b done=%b exp=%b, want digits=%h run=%b done=%b exp=%b",
               e.name, {seg3, seg2, seg1, seg0}, running, done, expired, e.cnt, e.run, e.dn, e.ex);
    end
  endtask

  task automatic ticks(input int from, input int n, input string name);
    for (int k = 1; k <= n; k++) step(mk(0, 1, 0, 0, 2'b00, 8'h00, bcd(from - k), 1, 0, 0, name));
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0, "reset");
    tbl[1]  = mk(0, 0, 0, 1, 2'b00, 8'h12, 16'h1200, 0, 0, 0, "load_sw12");
    tbl[2]  = mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h1200, 1, 0, 0, "start");
    tbl[3]  = mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h1199, 1, 0, 0, "tick1");
    tbl[4]  = mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h1198, 1, 0, 0, "tick2");
    tbl[5]  = mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h1197, 1, 0, 0, "tick3");
    tbl[6]  = mk(0, 1, 1, 0, 2'b00, 8'h00, 16'h1197, 0, 0, 0, "ss_over_tick");
    tbl[7]  = mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h1197, 0, 0, 0, "tick_in_pause");
    tbl[8]  = mk(0, 0, 1, 1, 2'b00, 8'h10, 16'h1000, 0, 0, 0, "load_over_ss");
    tbl[9]  = mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h1000, 1, 0, 0, "start2");
    tbl[10] = mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0999, 1, 0, 0, "borrow_chain");
    tbl[11] = mk(0, 0, 0, 1, 2'b00, 8'h55, 16'h0999, 1, 0, 0, "load_in_run");
    tbl[12] = mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h0999, 0, 0, 0, "pause");
    tbl[13] = mk(0, 0, 0, 1, 2'b00, 8'hAF, 16'h9900, 0, 0, 0, "clamp");
    tbl[14] = mk(0, 0, 0, 1, 2'b10, 8'h55, 16'h9900, 0, 0, 0, "mode10_ignored");
    tbl[15] = mk(0, 0, 0, 1, 2'b01, 8'h00, 16'h0100, 0, 0, 0, "default_preset");
    for (int i = 0; i < 16; i++) step(tbl[i]);
    step(mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h0100, 1, 0, 0, "start3"));
    ticks(100, 99, "count_down");
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    step(mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0100, 1, 0, 1, "auto_reload"));
    ticks(100, 99, "count_down2");
    step(mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0100, 1, 0, 1, "auto_reload2"));
    step(mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h0100, 0, 0, 0, "pause_auto"));
`else
    step(mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0000, 0, 1, 1, "terminal"));
    step(mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0000, 0, 1, 0, "expired_one_clk"));
    step(mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h0000, 0, 1, 0, "ss_in_done"));
    step(mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0000, 0, 1, 0, "tick_in_done"));
`endif
    step(mk(0, 0, 0, 1, 2'b00, 8'h08, 16'h0800, 0, 0, 0, "load_0800"));
    step(mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h0800, 1, 0, 0, "start4"));
    ticks(800, 66, "to_0734");
    step(mk(1, 1, 1, 1, 2'b00, 8'h12, 16'h0000, 0, 0, 0, "reset_mid_run"));
    step(mk(0, 0, 1, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0, "ss_at_zero"));
    step(mk(0, 1, 0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0, "tick_in_idle"));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
